stopwatch_core: RTL

Parametrised stopwatch/timer core: an N-digit BCD count, up or down, with start/pause, clear, lap-freeze, per-digit adjust and a countdown-expiry flag. It drives a time-multiplexed active-low seven-segment display. It sits between the debounced button/switch layer and the board display pins, and supersedes the fixed 4-digit counter.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 25 ++
 rtl/stopwatch_core.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, seven-segment codes and digit limits for the stopwatch
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_ADJUST,
        ST_EXPIRED
    } sw_state_e;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // In mm:ss format the tens digits (odd positions) only reach 5
    function automatic logic [3:0] digit_max(input int idx, input logic fmt);
        return (fmt && idx[0]) ? 4'd5 : 4'd9;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD to active-low seven-segment decoder, non-BCD codes blank
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - N-digit BCD stopwatch/countdown core with lap freeze, adjust and muxed display
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1,
    parameter int REFRESH_HZ = 1000,
    parameter int TIME_FMT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    input  logic                  mode_down,
    input  logic                  adj_en,
    input  logic [2:0]            adj_sel,
    input  logic [3:0]            adj_val,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  running,
    output logic                  lap_active,
    output logic                  expired
);

    localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ : 1;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REF_DIV  = (CLK_HZ / (REFRESH_HZ * N_DIGITS) > 1) ? CLK_HZ / (REFRESH_HZ * N_DIGITS) : 1;
    localparam int REF_W    = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
    localparam int IDX_W    = $clog2(N_DIGITS);
    localparam int CW       = 4 * N_DIGITS;
    localparam logic             FMT      = (TIME_FMT != 0);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    sw_state_e        state, state_nxt;
    logic [CW-1:0]    count, count_nxt, count_inc, count_dec, snapshot, shown;
    logic [PRE_W-1:0] pre, pre_nxt;
    logic             lap_nxt, expired_nxt, snap_load, tick, carry, borrow;
    logic [REF_W-1:0] ref_cnt;
    logic [IDX_W-1:0] scan_idx, scan_nxt;
    logic [3:0]       shown_digit;
    logic [6:0]       seg_code;

    assign digits = count;
    assign tick   = (state == ST_RUN) && (pre == PRE_LAST);

    // Ripple BCD increment/decrement, each digit wrapping at its own limit
    always_comb begin
        count_inc = count;
        count_dec = count;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] >= digit_max(i, FMT)) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = digit_max(i, FMT);
                end else begin
                    count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        pre_nxt     = pre;
        lap_nxt     = lap_active;
        expired_nxt = expired;
        snap_load   = 1'b0;
        if (clear) begin
            state_nxt   = ST_IDLE;
            count_nxt   = '0;
            pre_nxt     = '0;
            lap_nxt     = 1'b0;
            expired_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (adj_en) begin
                        state_nxt = ST_ADJUST;
                    end else if (start_stop) begin
                        state_nxt = ST_RUN;
                        pre_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    pre_nxt = tick ? '0 : pre + 1'b1;
                    if (tick) begin
                        if (!mode_down) begin
                            count_nxt = count_inc;
                        end else if (count == '0 || count_dec == '0) begin
                            state_nxt   = ST_EXPIRED;
                            expired_nxt = 1'b1;
                            count_nxt   = '0;
                        end else begin
                            count_nxt = count_dec;
                        end
                    end
                    // A tick in the same cycle is kept; expiry overrides the pause request
                    if (start_stop) begin
                        if (state_nxt == ST_RUN) state_nxt = ST_PAUSE;
                    end else if (lap) begin
                        lap_nxt   = ~lap_active;
                        snap_load = ~lap_active;
                    end
                end
                ST_PAUSE: begin
                    if (adj_en) begin
                        state_nxt = ST_ADJUST;
                    end else if (start_stop) begin
                        state_nxt = ST_RUN;
                    end else if (lap) begin
                        lap_nxt   = ~lap_active;
                        snap_load = ~lap_active;
                    end
                end
                ST_ADJUST: begin
                    expired_nxt = 1'b0;
                    if (!adj_en) begin
                        state_nxt = ST_PAUSE;
                    end else begin
                        for (int i = 0; i < N_DIGITS; i++) begin
                            if (int'(adj_sel) == i)
                                count_nxt[4*i +: 4] = (adj_val > digit_max(i, FMT)) ? digit_max(i, FMT) : adj_val;
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (adj_en) state_nxt = ST_ADJUST;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            pre        <= '0;
            snapshot   <= '0;
            lap_active <= 1'b0;
            expired    <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            pre        <= pre_nxt;
            lap_active <= lap_nxt;
            expired    <= expired_nxt;
            running    <= (state_nxt == ST_RUN);
            if (snap_load) snapshot <= count;
        end
    end

    // Scan index and the digit it selects are registered together so an/seg never mismatch
    assign shown    = lap_active ? snapshot : count;
    assign scan_nxt = (ref_cnt != REF_LAST) ? scan_idx :
                      (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;

    always_comb begin
        shown_digit = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IDX_W'(i) == scan_nxt) shown_digit = shown[4*i +: 4];
        end
    end

    seg7_decode u_seg7_decode (
        .bcd (shown_digit),
        .seg (seg_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
            an       <= {{(N_DIGITS-1){1'b1}}, 1'b0};
            seg      <= SEG_0;
        end else begin
            ref_cnt  <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
            scan_idx <= scan_nxt;
            an       <= ~({{(N_DIGITS-1){1'b0}}, 1'b1} << scan_nxt);
            seg      <= seg_code;
        end
    end

endmodule
